// File: rtl/pq_sequencer_if.sv
// Requester and RAM-port signals of the sorted priority-queue sequencer.
// The slave modport is the sequencer; the master side holds requester and RAM.
interface pq_sequencer_if #(
   parameter int KW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
);
   logic          i_enq;
   logic          i_deq;
   logic [KW-1:0] i_din;
   logic          o_ready;
   logic          o_deq_valid;
   logic [KW-1:0] o_deq_data;
   logic          o_err;
   logic [AW:0]   o_count;
   logic          o_full;
   logic          o_empty;
   logic [AW-1:0] o_ram_addr;
   logic          o_ram_we;
   logic [KW-1:0] o_ram_wdata;
   logic [KW-1:0] i_ram_rdata;

   modport slave (
      input  i_enq, i_deq, i_din, i_ram_rdata,
      output o_ready, o_deq_valid, o_deq_data, o_err, o_count, o_full, o_empty,
      output o_ram_addr, o_ram_we, o_ram_wdata
   );

   modport master (
      output i_enq, i_deq, i_din, i_ram_rdata,
      input  o_ready, o_deq_valid, o_deq_data, o_err, o_count, o_full, o_empty,
      input  o_ram_addr, o_ram_we, o_ram_wdata
   );
endinterface

// File: rtl/pq_sequencer.sv
// RAM-backed sorted priority queue sequencer: RAM[0..count-1] kept descending, minimum at the tail.
// Enqueue holds ready low 2*count+1 cycles (insertion walk); dequeue holds it low 2 cycles, data 3 cycles after accept.
module pq_sequencer #(
   parameter int KW    = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   pq_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENQ_RD,
      S_ENQ_CMP,
      S_ENQ_TAIL,
      S_DEQ_RD,
      S_DEQ_CAP
   } state_t;

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   state_t        r_state;
   logic [AW:0]   r_count;
   logic [KW-1:0] r_carry;
   logic [AW-1:0] r_addr;
   logic          r_deq_valid;
   logic [KW-1:0] r_deq_data;
   logic          r_err;

   logic          w_empty;
   logic          w_full;
   logic          w_swap;
   logic [AW:0]   w_addr_nxt;
   logic          w_last;
   logic          w_deq_go;
   logic          w_enq_go;
   logic          w_reject;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == LP_DEPTH);
   assign w_swap     = (r_carry >= bus.i_ram_rdata);
   assign w_addr_nxt = {1'b0, r_addr} + 1'b1;
   assign w_last     = (w_addr_nxt == r_count);

   // Dequeue wins a simultaneous request; the enqueue is simply not taken and must be re-presented.
   assign w_deq_go = bus.i_deq & ~w_empty;
   assign w_enq_go = bus.i_enq & ~w_full & ~w_deq_go;
   assign w_reject = (bus.i_deq & w_empty) | (bus.i_enq & w_full & ~bus.i_deq);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_count     <= '0;
         r_carry     <= '0;
         r_addr      <= '0;
         r_deq_valid <= 1'b0;
         r_deq_data  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_deq_valid <= 1'b0;
         r_err       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_err <= w_reject;
               if (w_deq_go) begin
                  r_addr  <= AW'(r_count - 1'b1);
                  r_state <= S_DEQ_RD;
               end else if (w_enq_go) begin
                  r_carry <= bus.i_din;
                  r_addr  <= '0;
                  r_state <= w_empty ? S_ENQ_TAIL : S_ENQ_RD;
               end
            end
            S_ENQ_RD: begin
               r_state <= S_ENQ_CMP;
            end
            S_ENQ_CMP: begin
               // The displaced (smaller) entry is carried down toward the tail.
               if (w_swap) begin
                  r_carry <= bus.i_ram_rdata;
               end
               r_addr  <= r_addr + 1'b1;
               r_state <= w_last ? S_ENQ_TAIL : S_ENQ_RD;
            end
            S_ENQ_TAIL: begin
               r_count <= r_count + 1'b1;
               r_addr  <= '0;
               r_state <= S_IDLE;
            end
            S_DEQ_RD: begin
               r_state <= S_DEQ_CAP;
            end
            S_DEQ_CAP: begin
               r_deq_data  <= bus.i_ram_rdata;
               r_deq_valid <= 1'b1;
               r_count     <= r_count - 1'b1;
               r_addr      <= '0;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // The swap write depends on read data arriving in the compare cycle, so the write strobe is decoded, not registered.
   assign bus.o_ram_we    = ~rst & (((r_state == S_ENQ_CMP) & w_swap) | (r_state == S_ENQ_TAIL));
   assign bus.o_ram_addr  = r_addr;
   assign bus.o_ram_wdata = r_carry;
   assign bus.o_ready     = ~rst & (r_state == S_IDLE);
   assign bus.o_deq_valid = r_deq_valid;
   assign bus.o_deq_data  = r_deq_data;
   assign bus.o_err       = r_err;
   assign bus.o_count     = r_count;
   assign bus.o_full      = w_full;
   assign bus.o_empty     = w_empty;

endmodule

// File: tb/tb_pq_sequencer.sv
// Randomized scoreboard bench for pq_sequencer against a queue-based reference model and a behavioural RAM.
module tb_pq_sequencer;
   localparam int KW    = 8;
   localparam int DEPTH = 16;

   typedef struct {
      logic [KW-1:0] key;
      int            cyc;
   } dexp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pq_sequencer_if #(.KW(KW), .DEPTH(DEPTH)) bus ();
   pq_sequencer #(.KW(KW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [KW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_wdata;
      bus.i_ram_rdata <= ram[bus.o_ram_addr];
   end

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int we_cnt = 0;
   logic [KW-1:0] model [$];
   dexp_t dq [$];
   int    eq [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   // Output monitor: every pop or error pulse must match a queued expectation.
   always @(negedge clk) begin
      if (bus.o_ram_we) we_cnt++;
      if (bus.o_deq_valid) begin
         chk("deq_valid_expected", int'(dq.size() > 0), 1);
         if (dq.size() > 0) begin
            dexp_t e;
            e = dq.pop_front();
            chk("deq_data", int'(bus.o_deq_data), int'(e.key));
            chk("deq_latency", cyc - e.cyc, 3);
         end
      end
      if (bus.o_err) begin
         chk("err_expected", int'(eq.size() > 0), 1);
         if (eq.size() > 0) begin
            int c;
            c = eq.pop_front();
            chk("err_latency", cyc - c, 1);
         end
      end
   end

   task automatic do_cmd(input bit e, input bit d, input logic [KW-1:0] k);
      int n, exp_busy, guard, busy, pos, mism;
      @(negedge clk);
      guard = 0;
      while (!bus.o_ready && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", int'(bus.o_ready), 1);
      n = model.size();
      exp_busy = 0;
      if (d && n > 0) begin
         dq.push_back('{model[n-1], cyc});
         void'(model.pop_back());
         exp_busy = 2;
      end else begin
         if (d) eq.push_back(cyc);
         if (e && n < DEPTH) begin
            pos = n;
            for (int i = 0; i < n; i++) begin
               if (k >= model[i]) begin
                  pos = i;
                  break;
               end
            end
            model.insert(pos, k);
            exp_busy = 2 * n + 1;
         end else if (e) begin
            eq.push_back(cyc);
         end
      end
      bus.i_enq = e;
      bus.i_deq = d;
      bus.i_din = k;
      @(posedge clk);
      #1;
      bus.i_enq = 1'b0;
      bus.i_deq = 1'b0;
      busy = 0;
      @(negedge clk);
      while (!bus.o_ready && busy < 300) begin
         busy++;
         @(negedge clk);
      end
      chk("busy_cycles", busy, exp_busy);
      chk("count", int'(bus.o_count), model.size());
      chk("full", int'(bus.o_full), int'(model.size() == DEPTH));
      chk("empty", int'(bus.o_empty), int'(model.size() == 0));
      mism = 0;
      for (int i = 0; i < model.size(); i++) if (ram[i] !== model[i]) mism++;
      chk("ram_content", mism, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int w0;
      bit e, d;
      logic [KW-1:0] k;
      bus.i_enq = 1'b0;
      bus.i_deq = 1'b0;
      bus.i_din = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_ready", int'(bus.o_ready), 0);
      chk("rst_ram_we", int'(bus.o_ram_we), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", int'(bus.o_ready), 1);
      chk("post_rst_count", int'(bus.o_count), 0);
      chk("post_rst_empty", int'(bus.o_empty), 1);
      chk("post_rst_full", int'(bus.o_full), 0);
      chk("post_rst_deq_valid", int'(bus.o_deq_valid), 0);
      chk("post_rst_err", int'(bus.o_err), 0);
      chk("post_rst_ram_addr", int'(bus.o_ram_addr), 0);
      chk("post_rst_deq_data", int'(bus.o_deq_data), 0);

      // Directed sort and drain.
      do_cmd(1, 0, 8'd7);
      do_cmd(1, 0, 8'd3);
      do_cmd(1, 0, 8'd9);
      do_cmd(1, 0, 8'd5);
      repeat (4) do_cmd(0, 1, 8'd0);

      // Dequeue while empty, then fill to capacity and overflow.
      do_cmd(0, 1, 8'd0);
      for (int i = 0; i < DEPTH; i++) do_cmd(1, 0, 8'($urandom_range(0, 255)));
      w0 = we_cnt;
      do_cmd(1, 0, 8'h42);
      chk("full_reject_no_write", we_cnt - w0, 0);
      repeat (DEPTH) do_cmd(0, 1, 8'd0);

      // Simultaneous requests: dequeue wins when non-empty; enqueue taken when empty.
      do_cmd(1, 0, 8'd8);
      do_cmd(1, 0, 8'd4);
      do_cmd(1, 1, 8'd6);
      do_cmd(0, 1, 8'd0);
      do_cmd(1, 1, 8'd17);
      do_cmd(0, 1, 8'd0);

      for (int n = 0; n < 200; n++) begin
         e = ($urandom_range(0, 99) < 60);
         d = ($urandom_range(0, 99) < 45);
         k = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
         if (e && d && model.size() == DEPTH) d = 1'b0;
         do_cmd(e, d, k);
      end
      while (model.size() > 0) do_cmd(0, 1, 8'd0);

      // Reset during the first compare cycle of an insertion walk.
      for (int i = 0; i < 5; i++) do_cmd(1, 0, 8'(10 + i));
      @(negedge clk);
      bus.i_enq = 1'b1;
      bus.i_din = 8'hFF;
      @(posedge clk);
      #1 bus.i_enq = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_ram_we", int'(bus.o_ram_we), 0);
      chk("midrst_ready", int'(bus.o_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      model.delete();
      @(negedge clk);
      chk("midrst_count", int'(bus.o_count), 0);
      chk("midrst_empty", int'(bus.o_empty), 1);
      chk("midrst_ready_after", int'(bus.o_ready), 1);
      do_cmd(1, 0, 8'd33);
      do_cmd(0, 1, 8'd0);

      repeat (5) @(negedge clk);
      chk("deq_drained", dq.size(), 0);
      chk("err_drained", eq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
